// File: rtl/cpu_pkg.sv
// Shared decode definitions for the IF->EX control unit: opcodes, control packet and decode helpers.
package cpu_pkg;

  localparam logic [6:0] R_TYPE  = 7'b0110011;
  localparam logic [6:0] I_IMM   = 7'b0010011;
  localparam logic [6:0] I_LOAD  = 7'b0000011;
  localparam logic [6:0] S_TYPE  = 7'b0100011;
  localparam logic [6:0] B_TYPE  = 7'b1100011;
  localparam logic [6:0] J_JAL   = 7'b1101111;
  localparam logic [6:0] I_JALR  = 7'b1100111;
  localparam logic [6:0] U_LUI   = 7'b0110111;
  localparam logic [6:0] U_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4,
    IMM_R = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic      mem_read;
    logic      mem_write;
    logic      reg_write;
    logic      jump;
    logic      branch;
    logic      alu_src;
    wb_sel_e   wb_sel;
    imm_type_e imm_type;
  } ctrl_t;

  function automatic ctrl_t decode_opcode(input logic [6:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      R_TYPE:  begin c.reg_write = 1'b1; c.wb_sel = WB_ALU; c.imm_type = IMM_R; end
      I_IMM:   begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.imm_type = IMM_I; end
      I_LOAD:  begin
        c.mem_read = 1'b1; c.reg_write = 1'b1; c.alu_src = 1'b1;
        c.wb_sel = WB_MEM; c.imm_type = IMM_I;
      end
      S_TYPE:  begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.imm_type = IMM_S; end
      B_TYPE:  begin c.branch = 1'b1; c.imm_type = IMM_B; end
      J_JAL:   begin c.reg_write = 1'b1; c.jump = 1'b1; c.wb_sel = WB_PC4; c.imm_type = IMM_J; end
      I_JALR:  begin
        c.reg_write = 1'b1; c.jump = 1'b1; c.alu_src = 1'b1;
        c.wb_sel = WB_PC4; c.imm_type = IMM_I;
      end
      U_LUI, U_AUIPC: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.imm_type = IMM_U; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Legal only for a known opcode in the 32-bit (low bits 2'b11) encoding space.
  function automatic logic is_legal(input logic [31:0] instr);
    logic known;
    case (instr[6:0])
      R_TYPE, I_IMM, I_LOAD, S_TYPE, B_TYPE,
      J_JAL, I_JALR, U_LUI, U_AUIPC: known = 1'b1;
      default:                       known = 1'b0;
    endcase
    return known & (instr[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/control_unit_pipe_if.sv
// Fetch-side and execute-side handshake bundle of control_unit_pipe, plus the pipeline flush.
interface control_unit_pipe_if
  import cpu_pkg::*;
#(
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [31:0]     out_instr;
  ctrl_t           out_ctrl;
  logic            illegal;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_ctrl, illegal
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_ctrl, illegal
  );
endinterface

// File: rtl/ctrl_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and full/empty flags (DEPTH a power of two).
module ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == CNT_W'(DEPTH));
  assign empty  = (count_r == {CNT_W{1'b0}});
  assign push_s = push & ~full & ~flush;
  assign pop_s  = pop & ~empty & ~flush;
  assign count  = count_r;
  assign rdata  = mem_r[rd_ptr_r];

  // Storage array; contents need no reset since empty entries are never presented.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; flush clears state just like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/control_unit_pipe.sv
// Registered, flow-controlled opcode decoder between IF and EX; buffers decoded entries in ctrl_fifo.
// Optional feature: define ILLEGAL_TRAP_EN to flag illegal encodings and squash their side effects.
module control_unit_pipe
  import cpu_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input logic                clk,
  input logic                rst_n,
  control_unit_pipe_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic            illegal;
    ctrl_t           ctrl;
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } entry_t;

  ctrl_t            raw_ctrl_s;
  ctrl_t            dec_ctrl_s;
  logic             dec_illegal_s;
  entry_t           wr_entry_s;
  entry_t           rd_entry_s;
  entry_t           head_s;
  logic             push_s;
  logic             pop_s;
  logic             full_s;
  logic             empty_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] count_nxt_s;
  logic             in_ready_r;

  // Decode of the incoming instruction; illegal entries lose every architectural side effect.
  always_comb begin
    raw_ctrl_s = decode_opcode(bus.in_instr[6:0]);
`ifdef ILLEGAL_TRAP_EN
    dec_illegal_s = ~is_legal(bus.in_instr);
`else
    dec_illegal_s = 1'b0;
`endif
    dec_ctrl_s           = raw_ctrl_s;
    dec_ctrl_s.reg_write = raw_ctrl_s.reg_write & ~dec_illegal_s;
    dec_ctrl_s.mem_write = raw_ctrl_s.mem_write & ~dec_illegal_s;
    dec_ctrl_s.mem_read  = raw_ctrl_s.mem_read & ~dec_illegal_s;
    dec_ctrl_s.jump      = raw_ctrl_s.jump & ~dec_illegal_s;
    dec_ctrl_s.branch    = raw_ctrl_s.branch & ~dec_illegal_s;
  end

  assign wr_entry_s = '{illegal: dec_illegal_s, ctrl: dec_ctrl_s,
                        instr: bus.in_instr, pc: bus.in_pc};
  assign push_s     = bus.in_valid & in_ready_r & ~full_s & ~bus.flush;
  assign pop_s      = ~empty_s & bus.out_ready & ~bus.flush;

  ctrl_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.flush),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wr_entry_s),
    .rdata (rd_entry_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Occupancy after this edge, so in_ready can be registered without seeing out_ready combinationally.
  always_comb begin
    count_nxt_s = count_s;
    if (bus.flush) begin
      count_nxt_s = {CNT_W{1'b0}};
    end else if (push_s && !pop_s) begin
      count_nxt_s = count_s + CNT_W'(1'b1);
    end else if (pop_s && !push_s) begin
      count_nxt_s = count_s - CNT_W'(1'b1);
    end else begin
      count_nxt_s = count_s;
    end
  end

  // in_ready is low throughout reset and reflects free space from the first post-reset edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_r <= 1'b0;
    end else begin
      in_ready_r <= (count_nxt_s < CNT_W'(DEPTH));
    end
  end

  assign head_s        = empty_s ? '0 : rd_entry_s;
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = ~empty_s;
  assign bus.out_pc    = head_s.pc;
  assign bus.out_instr = head_s.instr;
  assign bus.out_ctrl  = head_s.ctrl;
  assign bus.illegal   = head_s.illegal;
endmodule

// File: tb/tb_control_unit_pipe.sv
// Self-checking bench for control_unit_pipe: directed steps plus random traffic against a queue model.
module tb_control_unit_pipe;
  import cpu_pkg::*;

  localparam int PC_W  = 32;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  ent_t q[$];
  logic in_ready_m;

  control_unit_pipe_if #(.PC_W(PC_W)) bus ();

  control_unit_pipe #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written straight from the opcode table.
  function automatic ctrl_t exp_ctrl(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    if (instr[6:0] == 7'b0110011) begin c.reg_write = 1'b1; c.imm_type = IMM_R; end
    if (instr[6:0] == 7'b0010011) begin c.reg_write = 1'b1; c.alu_src = 1'b1; end
    if (instr[6:0] == 7'b0000011) begin
      c.mem_read = 1'b1; c.reg_write = 1'b1; c.alu_src = 1'b1; c.wb_sel = WB_MEM;
    end
    if (instr[6:0] == 7'b0100011) begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.imm_type = IMM_S; end
    if (instr[6:0] == 7'b1100011) begin c.branch = 1'b1; c.imm_type = IMM_B; end
    if (instr[6:0] == 7'b1101111) begin
      c.reg_write = 1'b1; c.jump = 1'b1; c.wb_sel = WB_PC4; c.imm_type = IMM_J;
    end
    if (instr[6:0] == 7'b1100111) begin
      c.reg_write = 1'b1; c.jump = 1'b1; c.alu_src = 1'b1; c.wb_sel = WB_PC4;
    end
    if (instr[6:0] == 7'b0110111 || instr[6:0] == 7'b0010111) begin
      c.reg_write = 1'b1; c.alu_src = 1'b1; c.imm_type = IMM_U;
    end
    return c;
  endfunction

  function automatic logic exp_illegal(input logic [31:0] instr);
    logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    logic known;
    known = 1'b0;
    foreach (ops[k]) if (instr[6:0] == ops[k]) known = 1'b1;
`ifdef ILLEGAL_TRAP_EN
    return ~known;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    ent_t h;
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(in_ready_m));
    if (q.size() != 0) begin
      h = q[0];
      chk("out_pc", 64'(bus.out_pc), 64'(h.pc));
      chk("out_instr", 64'(bus.out_instr), 64'(h.instr));
      chk("out_ctrl", 64'(bus.out_ctrl), 64'(exp_ctrl(h.instr)));
      chk("illegal", 64'(bus.illegal), 64'(exp_illegal(h.instr)));
    end else begin
      chk("empty_zero", {bus.out_pc, bus.out_instr} | 64'(bus.out_ctrl) | 64'(bus.illegal), 64'd0);
    end
  endtask

  // One clock: predict the handshake, advance the model, then compare on the far side of the edge.
  task automatic step();
    logic push_m;
    logic pop_m;
    ent_t e;
    push_m = rst_n && bus.in_valid && in_ready_m && !bus.flush;
    pop_m  = rst_n && (q.size() != 0) && bus.out_ready && !bus.flush;
    e.pc    = bus.in_pc;
    e.instr = bus.in_instr;
    @(posedge clk);
    #1;
    if (!rst_n || bus.flush) begin
      q.delete();
    end else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) q.push_back(e);
    end
    in_ready_m = rst_n && (q.size() < DEPTH);
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr(input logic [6:0] op);
    logic [31:0] r;
    r = $urandom;
    return {r[31:7], op};
  endfunction

  initial begin
    logic [6:0] sweep [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    logic [6:0] rnd_ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37,
                                 7'h17, 7'h7F, 7'h32};
    logic [31:0] pc;
    checks = 0;
    errors = 0;
    in_ready_m = 1'b0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h0000_1000;
    bus.in_instr = 32'h0000_2083;
    bus.out_ready = 1'b1;

    // Reset held with in_valid high: nothing may be accepted.
    repeat (3) step();
    chk("reset_in_ready", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    step();
    chk("post_reset_in_ready", 64'(bus.in_ready), 64'd1);

    // Decode sweep, one instruction per cycle with execute always ready.
    pc = 32'h0000_0100;
    bus.in_valid = 1'b1;
    bus.in_pc = pc;
    bus.in_instr = 32'h0000_2083;
    step();
    chk("lw_mem_read", 64'(bus.out_ctrl.mem_read), 64'd1);
    chk("lw_reg_write", 64'(bus.out_ctrl.reg_write), 64'd1);
    chk("lw_wb_sel", 64'(bus.out_ctrl.wb_sel), 64'd1);
    chk("lw_imm_type", 64'(bus.out_ctrl.imm_type), 64'(IMM_I));
    foreach (sweep[k]) begin
      pc += 32'd4;
      bus.in_pc = pc;
      bus.in_instr = rand_instr(sweep[k]);
      step();
    end
    bus.in_valid = 1'b1;
    bus.in_pc = 32'h0000_0200;
    bus.in_instr = 32'h0000_007F;
    step();
    chk("trap_illegal", 64'(bus.illegal), 64'(exp_illegal(32'h0000_007F)));
    chk("trap_ctrl_bits", 64'({bus.out_ctrl.reg_write, bus.out_ctrl.mem_write,
        bus.out_ctrl.mem_read, bus.out_ctrl.jump, bus.out_ctrl.branch}), 64'd0);
    bus.in_valid = 1'b0;
    step();

    // Backpressure: three offered, two held, then drained in order.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_pc = 32'h0000_3000 + 32'(i * 4);
      bus.in_instr = rand_instr(sweep[i]);
      step();
    end
    chk("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_head_pc", 64'(bus.out_pc), 64'h3000);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) step();
    chk("bp_drained", 64'(bus.out_valid), 64'd0);

    // Streaming: one in and one out per cycle.
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in_pc = 32'h0001_0000 + 32'(i * 4);
      bus.in_instr = rand_instr(rnd_ops[$urandom_range(8, 0)]);
      step();
    end
    bus.in_valid = 1'b0;
    step();

    // Flush with two entries buffered and a new one offered.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_pc = 32'h0000_4000 + 32'(i * 4);
      bus.in_instr = rand_instr(sweep[i]);
      step();
    end
    bus.flush = 1'b1;
    bus.in_pc = 32'h0000_4008;
    step();
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    step();

    // Random traffic with occasional flush and a reset mid-transfer.
    pc = 32'h0002_0000;
    for (int i = 0; i < 400; i++) begin
      rst_n = !(i == 200 || i == 201);
      bus.in_valid = ($urandom_range(3, 0) != 0);
      bus.out_ready = ($urandom_range(1, 0) != 0);
      bus.flush = ($urandom_range(15, 0) == 0);
      pc += 32'd4;
      bus.in_pc = pc;
      bus.in_instr = rand_instr(rnd_ops[$urandom_range(10, 0)]);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
